// File: rtl/trip_pkg.sv
// Shared types and constants for the trip controller. Optional reed lockout
// in trip_ctrl is enabled with the TRIP_CTRL_LOCKOUT_EN macro.
package trip_pkg;

  localparam int unsigned CIRC_W = 8;

  typedef enum logic [1:0] {
    S_DIST,
    S_SPEED,
    S_TIME,
    S_EDIT
  } state_t;

  localparam logic [1:0] DISP_DIST  = 2'd0;
  localparam logic [1:0] DISP_SPEED = 2'd1;
  localparam logic [1:0] DISP_TIME  = 2'd2;
  localparam logic [1:0] DISP_CIRC  = 2'd3;

  function automatic logic [CIRC_W-1:0] circ_inc(input logic [CIRC_W-1:0] v,
                                                 input logic [CIRC_W-1:0] wrap_to);
    return (v == '1) ? wrap_to : v + CIRC_W'(1);
  endfunction

  function automatic logic [1:0] disp_of(input state_t s);
    logic [1:0] d;
    d = DISP_DIST;
    case (s)
      S_DIST:  d = DISP_DIST;
      S_SPEED: d = DISP_SPEED;
      S_TIME:  d = DISP_TIME;
      S_EDIT:  d = DISP_CIRC;
      default: d = DISP_DIST;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/trip_ctrl_btn_press.sv
// btn_press: classifies a debounced button level into short/long press events.
// Events are single-cycle, valid on the release cycle (short) or the HOLD_CYCLES-th high cycle (long).
module btn_press
  import trip_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 200
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  input  logic inhibit,
  output logic short_ev,
  output logic long_ev
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD    = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          blocked_q, blocked_d;

  // Once inhibited, stay blocked until the button itself has been released,
  // so a press spanning the inhibit window never produces an event.
  always_comb begin
    cnt_d     = cnt_q;
    blocked_d = blocked_q;
    short_ev  = 1'b0;
    long_ev   = 1'b0;
    if (inhibit || blocked_q) begin
      cnt_d     = '0;
      blocked_d = inhibit | btn;
    end else if (btn) begin
      if (cnt_q != HOLD) cnt_d = cnt_q + CW'(1);
      long_ev = (cnt_q == HOLD_M1);
    end else begin
      short_ev = (cnt_q != '0) && (cnt_q != HOLD);
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      blocked_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      blocked_q <= blocked_d;
    end
  end

endmodule

// File: rtl/trip_ctrl.sv
// trip_ctrl: display mode FSM, circumference edit/commit and reed pulse qualifier.
// Define TRIP_CTRL_LOCKOUT_EN to add the reed re-trigger lockout counter.
module trip_ctrl
  import trip_pkg::*;
#(
  parameter logic [CIRC_W-1:0] CIRC_DEFAULT   = 8'd220,
  parameter logic [CIRC_W-1:0] CIRC_MIN       = 8'd150,
  parameter int unsigned       HOLD_CYCLES    = 200,
  parameter int unsigned       LOCKOUT_CYCLES = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode_btn,
  input  logic              set_btn,
  input  logic              reed_in,
  output logic              reed,
  output logic [CIRC_W-1:0] circ,
  output logic              dist_clear,
  output logic [1:0]        disp_sel,
  output logic              circ_edit,
  output logic [CIRC_W-1:0] circ_shadow
);

  logic mode_short, mode_long, set_short, set_long;

  btn_press #(.HOLD_CYCLES(HOLD_CYCLES)) u_mode_btn (
    .clock    (clock),
    .reset    (reset),
    .btn      (mode_btn),
    .inhibit  (1'b0),
    .short_ev (mode_short),
    .long_ev  (mode_long)
  );

  btn_press #(.HOLD_CYCLES(HOLD_CYCLES)) u_set_btn (
    .clock    (clock),
    .reset    (reset),
    .btn      (set_btn),
    .inhibit  (mode_btn),
    .short_ev (set_short),
    .long_ev  (set_long)
  );

  state_t            state_q, state_d;
  logic [CIRC_W-1:0] circ_q, circ_d;
  logic [CIRC_W-1:0] shadow_q, shadow_d;
  logic [1:0]        disp_sel_q, disp_sel_d;
  logic              circ_edit_q, circ_edit_d;
  logic              dist_clear_q, dist_clear_d;

  always_comb begin
    state_d      = state_q;
    circ_d       = circ_q;
    shadow_d     = shadow_q;
    dist_clear_d = 1'b0;
    if (state_q == S_EDIT) begin
      if (mode_long) begin
        state_d  = S_DIST;
        shadow_d = circ_q;
      end else if (mode_short) begin
        state_d = S_DIST;
        circ_d  = shadow_q;
      end else if (set_long) begin
        shadow_d = CIRC_DEFAULT;
      end else if (set_short) begin
        shadow_d = circ_inc(shadow_q, CIRC_MIN);
      end
    end else begin
      if (mode_long) begin
        state_d  = S_EDIT;
        shadow_d = circ_q;
      end else if (mode_short) begin
        case (state_q)
          S_DIST:  state_d = S_SPEED;
          S_SPEED: state_d = S_TIME;
          default: state_d = S_DIST;
        endcase
      end else if (set_long && state_q == S_DIST) begin
        dist_clear_d = 1'b1;
      end
    end
    disp_sel_d  = disp_of(state_d);
    circ_edit_d = (state_d == S_EDIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_DIST;
      circ_q       <= CIRC_DEFAULT;
      shadow_q     <= CIRC_DEFAULT;
      disp_sel_q   <= DISP_DIST;
      circ_edit_q  <= 1'b0;
      dist_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      circ_q       <= circ_d;
      shadow_q     <= shadow_d;
      disp_sel_q   <= disp_sel_d;
      circ_edit_q  <= circ_edit_d;
      dist_clear_q <= dist_clear_d;
    end
  end

  logic sync1_q, sync2_q, prev_q, reed_q;
  logic rise, reed_d;

  always_comb rise = sync2_q & ~prev_q;

`ifdef TRIP_CTRL_LOCKOUT_EN
  localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  logic [LOCK_W-1:0] lock_q, lock_d, lock_dec;

  // The pulse cycle counts as the first lockout cycle, so accepted pulses are
  // always at least LOCKOUT_CYCLES cycles apart.
  always_comb begin
    lock_dec = (lock_q == '0) ? '0 : lock_q - LOCK_W'(1);
    reed_d   = rise && (lock_dec == '0);
    lock_d   = reed_d ? LOCK_W'(LOCKOUT_CYCLES) : lock_dec;
  end

  always_ff @(posedge clock) begin
    if (reset) lock_q <= '0;
    else       lock_q <= lock_d;
  end
`else
  logic unused_lockout;
  always_comb begin
    reed_d         = rise;
    unused_lockout = (LOCKOUT_CYCLES != 0);
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      reed_q  <= 1'b0;
    end else begin
      sync1_q <= reed_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      reed_q  <= reed_d;
    end
  end

  assign reed        = reed_q;
  assign circ        = circ_q;
  assign dist_clear  = dist_clear_q;
  assign disp_sel    = disp_sel_q;
  assign circ_edit   = circ_edit_q;
  assign circ_shadow = shadow_q;

endmodule

// File: tb/tb_trip_ctrl.sv
// Self-checking bench for trip_ctrl: directed sequence plus randomized presses
// and reed activity, compared every cycle against a press-length based model.
module tb_trip_ctrl;

  localparam int HOLD = 200;
  localparam int LOCK = 20;
  localparam int CDEF = 220;
  localparam int CMIN = 150;

  logic       clock = 1'b0;
  logic       reset, mode_btn, set_btn, reed_in;
  logic       reed, dist_clear, circ_edit;
  logic [7:0] circ, circ_shadow;
  logic [1:0] disp_sel;

  always #5 clock = ~clock;

  trip_ctrl #(
    .CIRC_DEFAULT   (8'd220),
    .CIRC_MIN       (8'd150),
    .HOLD_CYCLES    (HOLD),
    .LOCKOUT_CYCLES (LOCK)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mode_btn    (mode_btn),
    .set_btn     (set_btn),
    .reed_in     (reed_in),
    .reed        (reed),
    .circ        (circ),
    .dist_clear  (dist_clear),
    .disp_sel    (disp_sel),
    .circ_edit   (circ_edit),
    .circ_shadow (circ_shadow)
  );

  int tests = 0;
  int failures = 0;

  // Reference model: display index, committed/edited circumference, press lengths.
  int m_disp, m_circ, m_shadow, m_reed, m_clear;
  int mode_len, set_len;
  bit set_block;
  bit rq[$];
  int cyc = 0;
  int last_pulse;
  int pulses = 0;
  int clears = 0;
  bit reed_rand = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_disp = 0; m_circ = CDEF; m_shadow = CDEF; m_reed = 0; m_clear = 0;
    mode_len = 0; set_len = 0; set_block = 1'b0;
    rq.delete();
    repeat (8) rq.push_back(1'b0);
    last_pulse = -1000;
  endtask

  task automatic model_edge();
    bit ms, ml, ss, sl, accept;
    cyc++;
    if (reset) begin
      model_reset();
      return;
    end
    // reed: sample at edge N shows up as a pulse after edge N+2
    rq.push_back(reed_in);
    if (rq.size() > 8) void'(rq.pop_front());
    m_reed = 0;
    if (rq[rq.size()-3] == 1'b1 && rq[rq.size()-4] == 1'b0) begin
`ifdef TRIP_CTRL_LOCKOUT_EN
      accept = (cyc - last_pulse) >= LOCK;
`else
      accept = 1'b1;
`endif
      if (accept) begin
        m_reed = 1;
        last_pulse = cyc;
      end
    end
    ms = 0; ml = 0; ss = 0; sl = 0;
    if (mode_btn) begin
      mode_len++;
      if (mode_len == HOLD) ml = 1;
    end else begin
      if (mode_len > 0 && mode_len < HOLD) ms = 1;
      mode_len = 0;
    end
    if (mode_btn) begin
      set_block = 1'b1; set_len = 0;
    end else if (set_block) begin
      set_len = 0;
      if (!set_btn) set_block = 1'b0;
    end else if (set_btn) begin
      set_len++;
      if (set_len == HOLD) sl = 1;
    end else begin
      if (set_len > 0 && set_len < HOLD) ss = 1;
      set_len = 0;
    end
    m_clear = 0;
    if (ml) begin
      m_disp = (m_disp == 3) ? 0 : 3;
      m_shadow = m_circ;
    end else if (ms) begin
      if (m_disp == 3) begin
        m_circ = m_shadow; m_disp = 0;
      end else begin
        m_disp = (m_disp + 1) % 3;
      end
    end else if (m_disp == 3) begin
      if (sl) m_shadow = CDEF;
      else if (ss) m_shadow = (m_shadow == 255) ? CMIN : m_shadow + 1;
    end else if (m_disp == 0 && sl) begin
      m_clear = 1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    chk("reed", 32'(reed), m_reed);
    chk("dist_clear", 32'(dist_clear), m_clear);
    chk("disp_sel", 32'(disp_sel), m_disp);
    chk("circ_edit", 32'(circ_edit), (m_disp == 3) ? 1 : 0);
    chk("circ", 32'(circ), m_circ);
    chk("circ_shadow", 32'(circ_shadow), m_shadow);
    if (reed === 1'b1) pulses++;
    if (dist_clear === 1'b1) clears++;
    if (reed_rand && $urandom_range(0, 3) == 0) reed_in = ~reed_in;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic press_mode(input int n);
    mode_btn = 1'b1; run(n);
    mode_btn = 1'b0; run(1);
  endtask

  task automatic press_set(input int n);
    set_btn = 1'b1; run(n);
    set_btn = 1'b0; run(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dur, kind, exp_toggle;
    reset = 1'b1; mode_btn = 1'b0; set_btn = 1'b0; reed_in = 1'b0;

    run(5);
    chk("rst_circ", 32'(circ), CDEF);
    chk("rst_shadow", 32'(circ_shadow), CDEF);
    chk("rst_disp", 32'(disp_sel), 0);
    chk("rst_pulses", 32'({reed, dist_clear, circ_edit}), 0);
    reset = 1'b0;
    run(3);

    // reed high 3 cycles every 50
    pulses = 0;
    for (int r = 0; r < 4; r++) begin
      reed_in = 1'b1; run(3);
      reed_in = 1'b0; run(47);
    end
    chk("reed_cnt_50", pulses, 4);

    // reed toggling every 5 cycles
    pulses = 0;
    for (int i = 0; i < 120; i++) begin
      reed_in = ((i / 5) % 2 == 0);
      tick();
    end
    reed_in = 1'b0; run(10);
`ifdef TRIP_CTRL_LOCKOUT_EN
    exp_toggle = 6;
`else
    exp_toggle = 12;
`endif
    chk("reed_cnt_toggle", pulses, exp_toggle);

    // mode cycling
    press_mode(10); chk("mode_cyc1", 32'(disp_sel), 1); run(5);
    press_mode(10); chk("mode_cyc2", 32'(disp_sel), 2); run(5);
    press_mode(10); chk("mode_cyc3", 32'(disp_sel), 0); run(5);

    // hold boundary
    press_mode(HOLD - 1); chk("hold_199_short", 32'(disp_sel), 1); run(3);
    mode_btn = 1'b1; run(HOLD);
    chk("hold_200_disp", 32'(disp_sel), 3);
    chk("hold_200_edit", 32'(circ_edit), 1);
    mode_btn = 1'b0; run(1);
    chk("long_release_none", 32'(disp_sel), 3);
    run(3);

    // edit: bring shadow to 250 and commit
    reed_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin press_set(3); run(1); end
    chk("shadow_250", 32'(circ_shadow), 250);
    press_mode(5);
    chk("commit_250", 32'(circ), 250);
    chk("commit_disp", 32'(disp_sel), 0);
    run(3);

    // edit, wrap, then abort
    press_mode(HOLD); run(2);
    for (int i = 0; i < 6; i++) begin
      press_set(4);
      if (i == 4) chk("shadow_255", 32'(circ_shadow), 255);
      run(1);
    end
    chk("shadow_wrap", 32'(circ_shadow), 150);
    press_set(HOLD + 3);
    chk("set_long_default", 32'(circ_shadow), CDEF);
    press_mode(HOLD + 5);
    chk("abort_circ", 32'(circ), 250);
    chk("abort_shadow", 32'(circ_shadow), 250);
    chk("abort_disp", 32'(disp_sel), 0);
    run(3);

    // edit, wrap, commit 150
    press_mode(HOLD); run(2);
    for (int i = 0; i < 6; i++) begin press_set(2); run(2); end
    press_mode(5);
    chk("commit_150", 32'(circ), 150);
    reed_rand = 1'b0; reed_in = 1'b0;
    run(5);

    // trip clear in S_DIST
    clears = 0;
    set_btn = 1'b1; run(HOLD - 1);
    chk("clear_before", 32'(dist_clear), 0);
    run(1);
    chk("clear_pulse", 32'(dist_clear), 1);
    run(1);
    chk("clear_single", 32'(dist_clear), 0);
    run(20);
    set_btn = 1'b0; run(2);
    chk("clear_cnt", clears, 1);

    // no clear in S_SPEED
    press_mode(5);
    clears = 0;
    press_set(HOLD + 10);
    chk("clear_speed", clears, 0);
    press_mode(5); run(1); press_mode(5); run(2);
    chk("back_dist", 32'(disp_sel), 0);

    // set held under mode: suppressed, even after mode release
    mode_btn = 1'b1; run(5);
    set_btn = 1'b1; run(300);
    mode_btn = 1'b0; run(250);
    set_btn = 1'b0; run(3);
    chk("suppress_disp", 32'(disp_sel), 3);
    chk("suppress_shadow", 32'(circ_shadow), 150);
    press_mode(HOLD + 2); run(2);

    // reset mid-edit
    press_mode(HOLD); run(2);
    for (int i = 0; i < 30; i++) begin press_set(1); run(1); end
    chk("shadow_180", 32'(circ_shadow), 180);
    reset = 1'b1; run(2);
    reset = 1'b0; run(1);
    chk("rst_edit_circ", 32'(circ), CDEF);
    chk("rst_edit_disp", 32'(disp_sel), 0);
    chk("rst_edit_flag", 32'(circ_edit), 0);

    // randomized presses with random reed activity
    reed_rand = 1'b1;
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 3));
      dur = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 20))
                                        : int'($urandom_range(HOLD - 5, HOLD + 5));
      case (kind)
        0: press_mode(dur);
        1, 3: press_set(dur);
        default: begin
          set_btn = 1'b1; run(dur);
          mode_btn = 1'b1; run(dur / 2 + 1);
          set_btn = 1'b0; run(2);
          mode_btn = 1'b0; run(1);
        end
      endcase
      run(int'($urandom_range(1, 8)));
    end
    reed_rand = 1'b0; reed_in = 1'b0;
    run(5);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/trip_ctrl.md
# trip_ctrl

Mode and configuration controller for the bike-computer datapath. It qualifies the raw reed switch into single-cycle `reed` pulses for the `distance` accumulator, and owns the wheel circumference register `circ` that feeds it. It also generates the trip-clear pulse and sequences the display selection through distance, speed, time and circumference edit. It sits between the user buttons, the reed input and the `distance`, speed and display blocks.

## Interface
Parameters:
- `CIRC_DEFAULT`, 8'd220: circumference (cm) loaded at reset.
- `CIRC_MIN`, 8'd150: wrap target when incrementing past 255.
- `HOLD_CYCLES`, 200: press length (cycles) classified as a long press.
- `LOCKOUT_CYCLES`, 20: reed re-trigger lockout (cycles).

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `mode_btn`  in  1  debounced mode button level, synchronous to `clock`.
- `set_btn`  in  1  debounced set button level, synchronous to `clock`.
- `reed_in`  in  1  raw asynchronous reed switch level.
- `reed`  out  1  one-cycle pulse per wheel revolution, to `distance`.
- `circ`  out  8  committed circumference (cm), to `distance`.
- `dist_clear`  out  1  one-cycle trip-clear pulse; top ORs it into the `distance` reset.
- `disp_sel`  out  2  0 = distance, 1 = speed, 2 = time, 3 = circumference.
- `circ_edit`  out  1  high while in edit state; display blinks.
- `circ_shadow`  out  8  value under edit; equals `circ` outside edit.

## Operation
- **Button classifier (per button).** A press starts a hold counter.
  - Release before `HOLD_CYCLES` gives one `short` event on the release cycle.
  - Counter reaching `HOLD_CYCLES` while held gives one `long` event immediately.
  - After a `long` event, the later release generates nothing.
  - Counter saturates.
- **FSM states:** `S_DIST`, `S_SPEED`, `S_TIME`, `S_EDIT`. `disp_sel` = 0/1/2/3 respectively.
- **Mode button:**
  - mode `short`: `S_DIST`→`S_SPEED`→`S_TIME`→`S_DIST`.
  - mode `short` in `S_EDIT`: commit `circ_shadow` to `circ`, go to `S_DIST`.
  - mode `long` in any show state: go to `S_EDIT`, with `circ_shadow` = `circ`.
  - mode `long` in `S_EDIT`: abort, discard shadow, go to `S_DIST`.
- **Set button:**
  - set `short` in `S_EDIT`: `circ_shadow` +1; 255 wraps to `CIRC_MIN`.
  - set `long` in `S_EDIT`: `circ_shadow` = `CIRC_DEFAULT`.
  - set `long` in `S_DIST`: `dist_clear` pulse.
  - All other set events are ignored.
- **Simultaneous buttons:** while `mode_btn` is high, set events are suppressed. The set classifier is held in idle and restarts only on a fresh set press after `mode_btn` releases.
- **Reed path:** 2-flop synchronizer, then rising-edge detect, then registered `reed` pulse. Reed pulses continue in every state, including `S_EDIT`. `distance` sees the committed `circ` only.
- **Commit and reed on the same cycle:** that reed pulse pairs with the old `circ`; `circ` updates on the following cycle.

## Timing
- **Reset values:**
  - `circ` = `circ_shadow` = `CIRC_DEFAULT`.
  - `disp_sel` = 0, state `S_DIST`.
  - `reed`, `dist_clear`, `circ_edit` = 0.
  - Synchronizers, counters and lockout cleared.
- **Reset mid-edit:** shadow is discarded and `circ` returns to `CIRC_DEFAULT`.
- **Reed latency:** `reed_in` high sampled at edge N gives `reed` high for exactly the cycle after edge N+2.
- **Lockout:** a `reed` pulse loads the lockout counter with `LOCKOUT_CYCLES`. Rising edges detected while the counter is nonzero are dropped, not deferred.
- **Button latency:** button events are registered. The state, `disp_sel` and `circ` change one cycle after the event cycle.
- **`dist_clear` timing:** asserted for one cycle, one cycle after the set `long` event.
- **Long-press boundary:** exactly `HOLD_CYCLES` high cycles counts as long; `HOLD_CYCLES`−1 counts as short.

## Configuration
- **`TRIP_CTRL_LOCKOUT_EN` defined:** reed lockout counter present, as above.
- **Undefined:** no lockout counter. Every synchronized rising edge of `reed_in` yields a `reed` pulse. `LOCKOUT_CYCLES` is unused.

## Structure
- **Package `trip_pkg`:**
  - FSM state enum.
  - `disp_sel` encodings `DISP_DIST`, `DISP_SPEED`, `DISP_TIME`, `DISP_CIRC`.
  - Circumference width constant `CIRC_W` = 8.
- **Sub-module `btn_press`:**
  - Parameter `HOLD_CYCLES`.
  - Ports: `clock`, `reset`, `btn`, `inhibit`, `short_ev`, `long_ev`.
  - Instantiated twice, once per button.
- **Top `trip_ctrl`:** FSM, circumference registers, reed path.

## Test plan
- **Reset:** reset for 5 cycles → `circ` = 220, `disp_sel` = 0, all pulses 0.
- **Reed pulses:** `reed_in` high 3 cycles every 50 cycles → `reed` pulse every 50 cycles, 3 cycles after each edge. `reed_in` toggling every 5 cycles with lockout 20 → one pulse per 20-cycle window; with the macro undefined, one pulse per edge.
- **Mode cycling and hold boundary:**
  - Mode pressed 10 cycles ×3 → `disp_sel` 0→1→2→0.
  - Mode held exactly 199 cycles → short action.
  - Mode held exactly 200 cycles → `S_EDIT`, `disp_sel` = 3, `circ_edit` = 1 on the cycle after the 200th high cycle.
- **Edit commit:** in edit, from 250, six set shorts → shadow 251…255, then 150; mode short → `circ` = 150, `S_DIST`. Mode long in edit instead → `circ` unchanged at 250.
- **Trip clear and priority:**
  - Set long in `S_DIST` → single `dist_clear` pulse.
  - Set long in `S_SPEED` → none.
  - Set pressed while mode held → no set event.
- **Reset mid-edit:** reset during edit with shadow 180 → `circ` = 220, state `S_DIST`.
